// File: rtl/period_meter.sv
// period_meter: measures rise-to-rise period and rise-to-fall high time of an
// asynchronous slow signal in inClk cycles, with result hold/ack and stall timeout.
`default_nettype none

module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             sigIn,
    input  logic             enable,
    input  logic             rdAck,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] highTime,
    output logic             valid,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_STALL   = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // sync_q[0]/[1] form the synchronizer, sync_q[2] is the history flop
    logic [2:0]       sync_q;
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hi_q,     hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic             valid_q,  valid_d;
    logic             over_q,   over_d;

    logic             rise;
    logic             fall;
    logic             new_result;
    logic [CNT_W-1:0] cnt_inc;

    assign rise    = sync_q[1] & ~sync_q[2];
    assign fall    = ~sync_q[1] & sync_q[2];
    assign cnt_inc = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + ONE_C;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        new_result = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
                S_ARM: begin
                    cnt_d = rise ? ONE_C : cnt_inc;
                    if (rise)
                        state_d = S_MEASURE;
                    else if (cnt_inc == TIMEOUT_C)
                        state_d = S_STALL;
                end
                S_MEASURE: begin
                    cnt_d = rise ? ONE_C : cnt_inc;
                    if (fall)
                        hi_d = cnt_q;
                    if (rise)
                        new_result = 1'b1;
                    else if (cnt_inc == TIMEOUT_C)
                        state_d = S_STALL;
                end
                default: begin
                    cnt_d = rise ? ONE_C : cnt_inc;
                    if (rise)
                        state_d = S_MEASURE;
                end
            endcase
        end
    end

    // A new result always wins over a coincident acknowledge
    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        valid_d  = valid_q;
        over_d   = over_q;
        if (new_result) begin
            period_d = cnt_q;
            high_d   = hi_q;
            valid_d  = 1'b1;
            over_d   = valid_q ? ~rdAck : over_q;
        end else if (rdAck && valid_q) begin
            valid_d = 1'b0;
            over_d  = 1'b0;
        end
    end

    always_ff @(posedge inClk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], sigIn};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            over_q   <= over_d;
        end
    end

    assign period   = period_q;
    assign highTime = high_q;
    assign valid    = valid_q;
    assign overrun  = over_q;
    assign timeout  = (state_q == S_STALL);

endmodule

`default_nettype wire
